// File: rtl/sub_bytes_serial.sv
// AES SubBytes over a state word. LANES bytes are substituted per cycle, so a word takes BEATS cycles. Valid/ready on both sides.
// Define SUB_BYTES_INV_EN to add per-lane inverse S-boxes selected by in_inv. Without it, every word gets forward substitution.
module sub_bytes_serial #(
  parameter int STATE_BYTES = 16,
  parameter int LANES       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_inv,
  input  logic [8*STATE_BYTES-1:0] in_state,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*STATE_BYTES-1:0] out_state,
  output logic                     busy
);
  localparam int BEATS = STATE_BYTES / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (LANES < 1 || LANES > STATE_BYTES || (STATE_BYTES % LANES) != 0) begin : g_bad_cfg
    $fatal(1, "sub_bytes_serial: STATE_BYTES must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t                   state_q;
  logic [BW-1:0]            beat_q;
  logic [8*STATE_BYTES-1:0] data_q, data_d;
  logic                     in_ready_q, out_valid_q, busy_q;
  int                       idx;

`ifdef SUB_BYTES_INV_EN
  logic inv_q;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Field inverse computed as a^254, which also maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

`ifdef SUB_BYTES_INV_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction
`endif

  always_comb begin
    data_d = data_q;
    idx    = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(beat_q) * LANES + l;
`ifdef SUB_BYTES_INV_EN
      data_d[idx*8 +: 8] = inv_q ? inv_sbox(data_q[idx*8 +: 8]) : fwd_sbox(data_q[idx*8 +: 8]);
`else
      data_d[idx*8 +: 8] = fwd_sbox(data_q[idx*8 +: 8]);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SUB_BYTES_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_state;
`ifdef SUB_BYTES_INV_EN
            inv_q      <= in_inv;
`endif
            beat_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SUB;
          end
        end
        SUB: begin
          data_q <= data_d;
          if (beat_q == BW'(BEATS - 1)) begin
            beat_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = data_q;
endmodule
